// File: rtl/shift_word_capture_ctrl.sv
// Serial-in word capture controller: arms on start, shifts qualified bits MSB-first,
// and presents each completed word on a valid/ready port with a sticky overrun flag.
module shift_word_capture_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in,
  input  logic             i_in_en,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_cont,
  input  logic             i_clr_ovr,
  input  logic             i_word_ready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_bit_count,
  output logic [WIDTH-1:0] o_word_out,
  output logic             o_word_valid,
  output logic             o_overrun
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_sreg;
  logic [CNT_W-1:0]   r_bit_count;
  logic [WIDTH-1:0]   r_word_out;
  logic               r_word_valid;
  logic               r_overrun;

  logic               w_arm;
  logic               w_sample;
  logic               w_complete;
  logic               w_xfer;
  logic [WIDTH-1:0]   w_word;

  // ABORT outranks both arming and completion, so it gates every shift-path qualifier.
  assign w_arm      = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_sample   = (r_state == S_SHIFT) && !i_abort && i_in_en;
  assign w_complete = w_sample && (r_bit_count == CNT_W'(WIDTH - 1));
  assign w_word     = {r_sreg[WIDTH-2:0], i_in};
  assign w_xfer     = r_word_valid && i_word_ready;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_arm) w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        if (i_abort)                   w_next_state = S_IDLE;
        else if (w_complete && !i_cont) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_sreg      <= '0;
      r_bit_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_sample) r_sreg <= w_word;
      if (w_arm || (r_state == S_SHIFT && i_abort) || w_complete)
        r_bit_count <= '0;
      else if (w_sample)
        r_bit_count <= r_bit_count + 1'b1;
    end
  end

  // A new word is accepted only into an empty or simultaneously drained output slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_complete && (!r_word_valid || w_xfer)) begin
        r_word_out   <= w_word;
        r_word_valid <= 1'b1;
      end else if (w_xfer) begin
        r_word_valid <= 1'b0;
      end

      if (w_complete && r_word_valid && !w_xfer) r_overrun <= 1'b1;
      else if (i_clr_ovr)                        r_overrun <= 1'b0;
    end
  end

  assign o_busy       = (r_state == S_SHIFT);
  assign o_bit_count  = r_bit_count;
  assign o_word_out   = r_word_out;
  assign o_word_valid = r_word_valid;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_shift_word_capture_ctrl.sv
// Self-checking bench for shift_word_capture_ctrl: expected words are queued as they
// are driven and popped when the DUT presents them.
module tb_shift_word_capture_ctrl;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_bit;
  logic             in_en;
  logic             start;
  logic             abort;
  logic             cont;
  logic             clr_ovr;
  logic             word_ready;
  logic             busy;
  logic [CNT_W-1:0] bit_count;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             overrun;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  shift_word_capture_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_in         (in_bit),
    .i_in_en      (in_en),
    .i_start      (start),
    .i_abort      (abort),
    .i_cont       (cont),
    .i_clr_ovr    (clr_ovr),
    .i_word_ready (word_ready),
    .o_busy       (busy),
    .o_bit_count  (bit_count),
    .o_word_out   (word_out),
    .o_word_valid (word_valid),
    .o_overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_cnt", 32'(bit_count), 32'd0);
  endtask

  task automatic send_bits(input logic [WIDTH-1:0] w, input int nbits, input bit toggle,
                           input bit ready_last, input bit clr_last, input bit cnt_chk);
    int exp_cnt = 0;
    for (int i = WIDTH - 1; i >= WIDTH - nbits; i--) begin
      if (toggle) begin
        in_en  = 1'b0;
        in_bit = ~w[i];
        tick();
        if (cnt_chk) check("stall_cnt", 32'(bit_count), 32'(exp_cnt));
      end
      in_en  = 1'b1;
      in_bit = w[i];
      if (i == 0) begin
        word_ready = ready_last;
        clr_ovr    = clr_last;
      end
      tick();
      exp_cnt = (exp_cnt + 1) % WIDTH;
      if (cnt_chk) check("step_cnt", 32'(bit_count), 32'(exp_cnt));
      word_ready = 1'b0;
      clr_ovr    = 1'b0;
    end
    in_en = 1'b0;
  endtask

  task automatic expect_word(input string tag);
    logic [WIDTH-1:0] exp_w;
    int n = 0;
    while (!word_valid && n < 4) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(word_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      exp_w = exp_q.pop_front();
      check({tag, "_word"}, 32'(word_out), 32'(exp_w));
    end
  endtask

  task automatic consume();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check("consume_valid", 32'(word_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_bit = 1'b0; in_en = 1'b0; start = 1'b0; abort = 1'b0;
    cont = 1'b0; clr_ovr = 1'b0; word_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(word_valid), 32'd0);
    check("rst_word", 32'(word_out), 32'd0);

    // Reset mid-SHIFT returns everything to zero.
    do_start();
    send_bits(16'hFFFF, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cnt", 32'(bit_count), 32'd0);
    check("midrst_valid", 32'(word_valid), 32'd0);
    check("midrst_ovr", 32'(overrun), 32'd0);

    // ABORT in IDLE blocks a simultaneous START.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);

    // Single word, contiguous bits; valid appears on the last-bit edge.
    do_start();
    send_bits(16'hA5C3, 15, 1'b0, 1'b0, 1'b0, 1'b1);
    check("pre_last_valid", 32'(word_valid), 32'd0);
    in_en = 1'b1; in_bit = 1'b1;
    exp_q.push_back(16'hA5C3);
    tick();
    in_en = 1'b0;
    check("single_valid_now", 32'(word_valid), 32'd1);
    check("single_busy", 32'(busy), 32'd0);
    check("single_cnt", 32'(bit_count), 32'd0);
    expect_word("single");
    consume();

    // Same stream with IN_EN toggling; count only advances on enabled cycles.
    do_start();
    exp_q.push_back(16'hA5C3);
    send_bits(16'hA5C3, 16, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_word("toggle");
    check("toggle_busy", 32'(busy), 32'd0);
    consume();

    // Continuous mode, no consumer: second word dropped, set beats clear.
    cont = 1'b1;
    do_start();
    exp_q.push_back(16'h1234);
    send_bits(16'h1234, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_word("cont1");
    send_bits(16'hBEEF, 16, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_word_held", 32'(word_out), 32'h1234);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_busy", 32'(busy), 32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_clear", 32'(overrun), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ovr_abort_busy", 32'(busy), 32'd0);
    consume();

    // Continuous mode with a transfer coinciding with the second word's last bit.
    do_start();
    exp_q.push_back(16'h1234);
    send_bits(16'h1234, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_word("xfer1");
    exp_q.push_back(16'hBEEF);
    send_bits(16'hBEEF, 16, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_word("xfer2");
    check("xfer_ovr", 32'(overrun), 32'd0);
    check("xfer_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    consume();
    cont = 1'b0;

    // ABORT after 7 bits discards the partial word.
    do_start();
    send_bits(16'hFFFF, 7, 1'b0, 1'b0, 1'b0, 1'b0);
    check("abort_pre_cnt", 32'(bit_count), 32'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cnt", 32'(bit_count), 32'd0);
    check("abort_valid", 32'(word_valid), 32'd0);
    do_start();
    exp_q.push_back(16'h00FF);
    send_bits(16'h00FF, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_word("after_abort");
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
